// File: rtl/sevseg_pkg.sv
// Shared types and the hex-to-seven-segment table for the scan controller family.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package sevseg_pkg;
   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG7_OFF = 7'h7F;

   localparam seg7_t SEG7_HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
endpackage

// File: rtl/sevseg_hex_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module sevseg_hex_decoder
   import sevseg_pkg::*;
(
   input  logic [3:0] nibble,
   output seg7_t      seg
);
   assign seg = SEG7_HEX[nibble];
endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with refresh prescaler, frame snapshot,
// leading-zero suppression, blink and anti-ghost blanking; all pad outputs registered.
module sevseg_scan_ctrl
   import sevseg_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int REFRESH_DIV    = 4096,
   parameter int BLANK_CYCLES   = 64,
   parameter int BLINK_DIV_LOG2 = 21
) (
   input  logic                    clk_5mhz0d,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] hex_val,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lz_suppress,
   output logic [6:0]              seg_active_n,
   output logic                    dp_active_n,
   output logic [NUM_DIGITS-1:0]   anodes,
   output logic                    frame_strobe
);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PC_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] PC_BLANK = PW'(BLANK_CYCLES);
   localparam logic [DW-1:0] D_LAST   = DW'(NUM_DIGITS - 1);

   generate
      if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
         $error("sevseg_scan_ctrl: NUM_DIGITS must be 1..16");
      end
      if (REFRESH_DIV < BLANK_CYCLES + 2) begin : g_bad_refresh_div
         $error("sevseg_scan_ctrl: REFRESH_DIV must be >= BLANK_CYCLES+2");
      end
   endgenerate

   logic [PW-1:0]             pc_reg;
   logic [DW-1:0]             d_reg;
   logic [BLINK_DIV_LOG2-1:0] blink_cnt_reg;
   logic                      blink_phase_reg;

   logic [4*NUM_DIGITS-1:0]   shadow_hex_reg;
   logic [NUM_DIGITS-1:0]     shadow_en_reg;
   logic [NUM_DIGITS-1:0]     shadow_dp_reg;
   logic [NUM_DIGITS-1:0]     shadow_blink_reg;
   logic                      shadow_lz_reg;

   logic                      pc_wrap;
   logic                      frame_end;
   logic [3:0]                nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]     lz_blank;
   logic                      zero_run;
   logic [3:0]                cur_nib;
   seg7_t                     cur_seg;
   logic [NUM_DIGITS-1:0]     anodes_next;
   seg7_t                     seg_next;
   logic                      dp_next;

   assign pc_wrap   = (pc_reg == PC_LAST);
   assign frame_end = pc_wrap && (d_reg == D_LAST);

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
         assign nib[gi] = shadow_hex_reg[4*gi +: 4];
      end
   endgenerate

   // A digit is a leading zero if it and every digit above it is zero or disabled.
   always_comb begin
      zero_run = shadow_lz_reg;
      lz_blank = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run    = zero_run && (!shadow_en_reg[i] || (nib[i] == 4'h0));
         lz_blank[i] = zero_run;
      end
   end

   assign cur_nib = nib[d_reg];

   sevseg_hex_decoder u_hex_decoder (
      .nibble (cur_nib),
      .seg    (cur_seg)
   );

   always_comb begin
      anodes_next = '1;
      if (pc_reg >= PC_BLANK && shadow_en_reg[d_reg] &&
          !(blink_phase_reg && shadow_blink_reg[d_reg])) begin
         anodes_next[d_reg] = 1'b0;
      end
      seg_next = lz_blank[d_reg] ? SEG7_OFF : cur_seg;
      dp_next  = ~shadow_dp_reg[d_reg];
   end

   always_ff @(posedge clk_5mhz0d) begin
      if (!rst_n) begin
         pc_reg           <= '0;
         d_reg            <= '0;
         blink_cnt_reg    <= '0;
         blink_phase_reg  <= 1'b0;
         shadow_hex_reg   <= '0;
         shadow_en_reg    <= '0;
         shadow_dp_reg    <= '0;
         shadow_blink_reg <= '0;
         shadow_lz_reg    <= 1'b0;
         anodes           <= '1;
         seg_active_n     <= SEG7_OFF;
         dp_active_n      <= 1'b1;
         frame_strobe     <= 1'b0;
      end else begin
         blink_cnt_reg <= blink_cnt_reg + 1'b1;
         if (&blink_cnt_reg) begin
            blink_phase_reg <= ~blink_phase_reg;
         end
         if (pc_wrap) begin
            pc_reg <= '0;
            d_reg  <= (d_reg == D_LAST) ? '0 : d_reg + 1'b1;
         end else begin
            pc_reg <= pc_reg + 1'b1;
         end
         // Shadow registers only change at the frame boundary so a frame never tears.
         if (frame_end) begin
            shadow_hex_reg   <= hex_val;
            shadow_en_reg    <= digit_en;
            shadow_dp_reg    <= dp_mask;
            shadow_blink_reg <= blink_mask;
            shadow_lz_reg    <= lz_suppress;
         end
         anodes       <= anodes_next;
         seg_active_n <= seg_next;
         dp_active_n  <= dp_next;
         frame_strobe <= frame_end;
      end
   end
endmodule
